// File: rtl/yarvi_fetch_pkg.sv
// Shared fetch constants and the {pc, insn} buffer entry type for the yarvi fetch front end.
package yarvi_fetch_pkg;

    localparam int VMSB = 63;

    localparam logic [VMSB:0] RESET_PC_DEFAULT = (VMSB+1)'('h8000_0000);
    localparam logic [VMSB:0] PC_STEP          = (VMSB+1)'(4);
    localparam logic [VMSB:0] ALIGN_MASK       = ~((VMSB+1)'(3));

    typedef struct packed {
        logic [VMSB:0] pc;
        logic [31:0]   insn;
    } fetch_entry_t;

    function automatic logic [VMSB:0] align_word(input logic [VMSB:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/yarvi_fetch_fifo.sv
// Synchronous instruction buffer of {pc, insn} entries with flush; head is read straight from storage.
module yarvi_fetch_fifo
    import yarvi_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/yarvi_fetch.sv
// Fetch front end: PC, credit-limited imem requests, response buffering and restart squash.
// Optional misaligned-target detection is enabled by defining YARVI_FETCH_ALIGN_CHECK_EN.
module yarvi_fetch
    import yarvi_fetch_pkg::*;
#(
    parameter logic [VMSB:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int            FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ex_restart,
    input  logic [VMSB:0]   ex_restart_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [VMSB:0]   imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            de_ready,
    output logic            fe_valid,
    output logic [VMSB:0]   fe_pc,
    output logic [31:0]     fe_insn
`ifdef YARVI_FETCH_ALIGN_CHECK_EN
    ,
    output logic            fe_misaligned
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [VMSB:0]    pc;
    logic [VMSB:0]    resp_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;
    logic             credit_ok;
    logic             fetch_blocked;
    logic [VMSB:0]    restart_target;

`ifdef YARVI_FETCH_ALIGN_CHECK_EN
    logic misaligned_q;
    assign fe_misaligned  = misaligned_q;
    assign fetch_blocked  = misaligned_q;
    assign restart_target = ex_restart_pc;
`else
    assign fetch_blocked  = 1'b0;
    assign restart_target = align_word(ex_restart_pc);
`endif

    // A slot popped this cycle is free before any new response can land, which sustains one word per cycle.
    assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count} - (CNT_W+1)'(pop);
    assign credit_ok      = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    assign imem_req_valid = reset_n & ~ex_restart & ~fetch_blocked & credit_ok;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign push            = imem_resp_valid & ~ex_restart & (drop == '0);
    assign push_entry.pc   = resp_pc;
    assign push_entry.insn = imem_resp_data;

    assign fe_valid = reset_n & ~fifo_empty & ~ex_restart;
    assign fe_pc    = fifo_head.pc;
    assign fe_insn  = fifo_head.insn;
    assign pop      = fe_valid & de_ready;

    yarvi_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (ex_restart),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Requests are blocked during a restart, so every request left outstanding afterwards is stale.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
`ifdef YARVI_FETCH_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            inflight <= inflight + CNT_W'(accept) - CNT_W'(imem_resp_valid);
            if (ex_restart) begin
                pc      <= restart_target;
                resp_pc <= restart_target;
                drop    <= inflight - CNT_W'(imem_resp_valid);
`ifdef YARVI_FETCH_ALIGN_CHECK_EN
                misaligned_q <= |ex_restart_pc[1:0];
`endif
            end else begin
                if (accept) pc <= pc + PC_STEP;
                if (push) resp_pc <= resp_pc + PC_STEP;
                if (imem_resp_valid && drop != '0) drop <= drop - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_yarvi_fetch.sv
// Directed bench for yarvi_fetch with an in-order, fixed-latency instruction memory model.
module tb_yarvi_fetch;

    logic        clock;
    logic        reset_n;
    logic        ex_restart;
    logic [63:0] ex_restart_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        de_ready;
    logic        fe_valid;
    logic [63:0] fe_pc;
    logic [31:0] fe_insn;
`ifdef YARVI_FETCH_ALIGN_CHECK_EN
    logic        fe_misaligned;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    pending[$];
    logic [63:0] accept_log[$];
    int          accept_count = 0;
    int          mem_cycle    = 0;
    int          mem_latency  = 1;

    yarvi_fetch dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ex_restart      (ex_restart),
        .ex_restart_pc   (ex_restart_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .de_ready        (de_ready),
        .fe_valid        (fe_valid),
        .fe_pc           (fe_pc),
        .fe_insn         (fe_insn)
`ifdef YARVI_FETCH_ALIGN_CHECK_EN
        ,
        .fe_misaligned   (fe_misaligned)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] insn_for(input logic [63:0] addr);
        return addr[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory answers each accepted request exactly mem_latency cycles later, in order; reset clears it.
    initial begin : responder
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_cycle++;
            if (pending.size() > 0 && pending[0].due == mem_cycle) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = insn_for(pending[0].addr);
                void'(pending.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
            end
            @(negedge clock);
            if (!reset_n) begin
                pending.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                pending.push_back('{addr: imem_req_addr, due: mem_cycle + mem_latency});
                accept_log.push_back(imem_req_addr);
                accept_count++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, return at the falling edge for sampling.
    task automatic applyStimulus(input logic rst_n, input logic restart, input logic [63:0] rpc,
                                 input logic ready, input logic de_rdy);
        @(posedge clock);
        #1;
        reset_n        = rst_n;
        ex_restart     = restart;
        ex_restart_pc  = rpc;
        imem_req_ready = ready;
        de_ready       = de_rdy;
        @(negedge clock);
    endtask

    task automatic wait_req(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
            if (imem_req_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fe(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
            if (fe_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(input int latency);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        mem_latency = latency;
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    endtask

    initial begin : stimulus
        logic        found;
        logic [63:0] held_pc;
        logic [31:0] held_insn;
        logic [63:0] pend_addr;
        logic [63:0] last_fe;
        logic        pend_valid;
        logic        have_last;
        int          base;
        int          unstable;
        int          held_err;
        int          seq_err;
        int          log_err;
        int          fe_seen;

        reset_n        = 1'b0;
        ex_restart     = 1'b0;
        ex_restart_pc  = '0;
        imem_req_ready = 1'b1;
        de_ready       = 1'b1;

        // Reset state and release, L=1.
        do_reset(1);
        checkOutput("reset_req_valid", imem_req_valid, 1'b0);
        checkOutput("reset_fe_valid",  fe_valid, 1'b0);
        checkOutput("reset_pc",        imem_req_addr, 64'h8000_0000);

        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("c0_req_valid", imem_req_valid, 1'b1);
        checkOutput("c0_req_addr",  imem_req_addr, 64'h8000_0000);
        checkOutput("c0_fe_valid",  fe_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("c1_req_addr",  imem_req_addr, 64'h8000_0004);
        checkOutput("c1_fe_valid",  fe_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("c2_req_addr",  imem_req_addr, 64'h8000_0008);
        checkOutput("c2_fe_valid",  fe_valid, 1'b1);
        checkOutput("c2_fe_pc",     fe_pc, 64'h8000_0000);
        checkOutput("c2_fe_insn",   fe_insn, insn_for(64'h8000_0000));
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("c3_req_addr",  imem_req_addr, 64'h8000_000C);
        checkOutput("c3_fe_valid",  fe_valid, 1'b1);
        checkOutput("c3_fe_pc",     fe_pc, 64'h8000_0004);

        // Restart with two requests in flight, L=3.
        do_reset(3);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h8000_0100, 1'b1, 1'b1);
        checkOutput("rs2_req_valid_in_restart", imem_req_valid, 1'b0);
        checkOutput("rs2_fe_valid_in_restart",  fe_valid, 1'b0);
        wait_req(12, found);
        checkOutput("rs2_req_found", found, 1'b1);
        checkOutput("rs2_req_addr",  imem_req_addr, 64'h8000_0100);
        wait_fe(12, found);
        checkOutput("rs2_fe_found", found, 1'b1);
        checkOutput("rs2_fe_pc",    fe_pc, 64'h8000_0100);
        checkOutput("rs2_fe_insn",  fe_insn, insn_for(64'h8000_0100));

        // Restart in the same cycle as a response, L=1.
        do_reset(1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h8000_0300, 1'b1, 1'b1);
        checkOutput("co_resp_in_restart",       imem_resp_valid, 1'b1);
        checkOutput("co_fe_valid_in_restart",   fe_valid, 1'b0);
        checkOutput("co_req_valid_in_restart",  imem_req_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("co_req_valid_after", imem_req_valid, 1'b1);
        checkOutput("co_req_addr_after",  imem_req_addr, 64'h8000_0300);
        wait_fe(10, found);
        checkOutput("co_fe_found", found, 1'b1);
        checkOutput("co_fe_pc",    fe_pc, 64'h8000_0300);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("co_fe_valid_next", fe_valid, 1'b1);
        checkOutput("co_fe_pc_next",    fe_pc, 64'h8000_0304);

        // Consumer back-pressure for 10 cycles.
        #1;
        base = accept_count;
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("bp_fe_valid_start", fe_valid, 1'b1);
        held_pc   = fe_pc;
        held_insn = fe_insn;
        unstable  = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
            if (!fe_valid || fe_pc !== held_pc || fe_insn !== held_insn) unstable++;
        end
        checkOutput("bp_stable",       64'(unstable), 64'd0);
        checkOutput("bp_req_valid",    imem_req_valid, 1'b0);
        checkOutput("bp_held_insn",    held_insn, insn_for(held_pc));
        #1;
        checkOutput("bp_accept_bound", 64'((accept_count - base) <= 2), 64'd1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("bp_rel0_pc", fe_pc, held_pc);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("bp_rel1_valid", fe_valid, 1'b1);
        checkOutput("bp_rel1_pc",    fe_pc, held_pc + 64'd4);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("bp_rel2_valid", fe_valid, 1'b1);
        checkOutput("bp_rel2_pc",    fe_pc, held_pc + 64'd8);

        // Memory request stalls: ready alternates 0/1.
        #1;
        accept_log.delete();
        pend_valid = 1'b0;
        pend_addr  = '0;
        have_last  = 1'b0;
        last_fe    = '0;
        held_err   = 0;
        seq_err    = 0;
        fe_seen    = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 1'(i % 2), 1'b1);
            if (pend_valid && imem_req_valid && imem_req_addr !== pend_addr) held_err++;
            if (imem_req_valid && !imem_req_ready) begin
                pend_valid = 1'b1;
                pend_addr  = imem_req_addr;
            end else if (imem_req_valid) begin
                pend_valid = 1'b0;
            end
            if (fe_valid) begin
                if (have_last && fe_pc !== last_fe + 64'd4) seq_err++;
                last_fe   = fe_pc;
                have_last = 1'b1;
                fe_seen++;
            end
        end
        #1;
        log_err = 0;
        for (int k = 1; k < accept_log.size(); k++) begin
            if (accept_log[k] !== accept_log[k-1] + 64'd4) log_err++;
        end
        checkOutput("stall_addr_held",   64'(held_err), 64'd0);
        checkOutput("stall_fe_sequence", 64'(seq_err), 64'd0);
        checkOutput("stall_req_sequence", 64'(log_err), 64'd0);
        checkOutput("stall_req_progress", 64'(accept_log.size() >= 4), 64'd1);
        checkOutput("stall_fe_progress",  64'(fe_seen >= 3), 64'd1);

        // Restart to a misaligned target.
        applyStimulus(1'b1, 1'b1, 64'h8000_0102, 1'b1, 1'b1);
        checkOutput("mis_fe_valid_in_restart", fe_valid, 1'b0);
`ifdef YARVI_FETCH_ALIGN_CHECK_EN
        held_err = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
            if (fe_misaligned !== 1'b1 || imem_req_valid !== 1'b0) held_err++;
        end
        checkOutput("mis_flag_blocks", 64'(held_err), 64'd0);
        applyStimulus(1'b1, 1'b1, 64'h8000_0200, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("mis_flag_cleared", fe_misaligned, 1'b0);
        if (!imem_req_valid) wait_req(12, found);
        checkOutput("mis_req_addr", imem_req_addr, 64'h8000_0200);
`else
        wait_req(12, found);
        checkOutput("mis_req_found", found, 1'b1);
        checkOutput("mis_req_addr",  imem_req_addr, 64'h8000_0100);
        wait_fe(12, found);
        checkOutput("mis_fe_found", found, 1'b1);
        checkOutput("mis_fe_pc",    fe_pc, 64'h8000_0100);
        checkOutput("mis_fe_insn",  fe_insn, insn_for(64'h8000_0100));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
